// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 6-digit common-anode 7-segment display.
// Define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seg_scan_ctrl #(
    parameter logic [15:0] CLK_DIV      = 16'd50000,
    parameter logic [15:0] BLANK_CYCLES = 16'd500
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        en,
    input  logic [23:0] din,
    input  logic [5:0]  dp_in,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        frame_done,
    output logic [5:0]  sel,
    output logic [7:0]  seg_led
);

    localparam logic [15:0] SlotLast  = CLK_DIV - 16'd1;
    localparam logic [15:0] BlankLast = BLANK_CYCLES - 16'd1;
    localparam logic [2:0]  LastDigit = 3'd5;

    typedef enum logic [1:0] {
        StOff,
        StBlank,
        StDrive
    } state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [23:0] disp_word_q;
    logic [5:0]  disp_dp_q;
    logic [23:0] pend_word_q;
    logic [5:0]  pend_dp_q;
    logic        pend_full_q;

    logic        accept;
    logic        slot_end;
    logic        frame_end;
    logic [3:0]  cur_nib;
    logic        cur_dp;
    logic [5:0]  lead_blank;
    logic [7:0]  drive_seg;

    // Segment pattern for a hex nibble, {g,f,e,d,c,b,a}, low = lit.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    assign din_ready = ~pend_full_q;
    assign accept    = din_valid & ~pend_full_q;
    assign slot_end  = (state_q == StDrive) && (cnt_q == SlotLast);
    assign frame_end = slot_end && (idx_q == LastDigit);
    assign cur_nib   = disp_word_q[{idx_q, 2'b00} +: 4];
    assign cur_dp    = disp_dp_q[idx_q];

`ifdef LEAD_ZERO_BLANK_EN
    // A digit blanks only if it and every digit to its left is zero with its dp off.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        lead_blank = '0;
        for (int k = 5; k >= 1; k--) begin
            zero_run      = zero_run && (disp_word_q[4*k +: 4] == 4'd0) && !disp_dp_q[k];
            lead_blank[k] = zero_run;
        end
    end
`else
    assign lead_blank = '0;
`endif

    always_comb begin
        drive_seg = {~cur_dp, seg_decode(cur_nib)};
        if (lead_blank[idx_q]) begin
            drive_seg = 8'hFF;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= StOff;
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_word_q <= '0;
            disp_dp_q   <= '0;
            pend_word_q <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            sel         <= 6'h3F;
            seg_led     <= 8'hFF;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Pins follow the state of the previous cycle.
            if (state_q == StDrive) begin
                sel     <= ~(6'd1 << idx_q);
                seg_led <= drive_seg;
            end else begin
                sel     <= 6'h3F;
                seg_led <= 8'hFF;
            end

            if (accept) begin
                pend_word_q <= din;
                pend_dp_q   <= dp_in;
                pend_full_q <= 1'b1;
            end

            if (!en) begin
                state_q <= StOff;
                cnt_q   <= '0;
                idx_q   <= '0;
                // Nothing is lit, so a waiting word can be shown without tearing.
                if (pend_full_q) begin
                    disp_word_q <= pend_word_q;
                    disp_dp_q   <= pend_dp_q;
                    pend_full_q <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    StOff: begin
                        state_q <= StBlank;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                    StBlank: begin
                        cnt_q <= cnt_q + 16'd1;
                        if (cnt_q == BlankLast) begin
                            state_q <= StDrive;
                        end
                    end
                    StDrive: begin
                        if (slot_end) begin
                            state_q <= StBlank;
                            cnt_q   <= '0;
                            idx_q   <= (idx_q == LastDigit) ? 3'd0 : idx_q + 3'd1;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= StOff;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                endcase

                if (frame_end) begin
                    frame_done <= 1'b1;
                    if (pend_full_q) begin
                        disp_word_q <= pend_word_q;
                        disp_dp_q   <= pend_dp_q;
                        pend_full_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
